// File: rtl/dmem_responder_if.sv
// Request/response bus between the EX/MEM initiator and the data-memory responder.
// The master modport is the initiator side, the slave modport is the responder.
interface dmem_responder_if #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [DM_ADDRESS-1:0] req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [2:0]            req_funct3;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-addressed little-endian store with RV32I load/store
// sizing, sign/zero extension and a programmable access latency (WAIT_CYCLES).
// Optional feature macro: DMEM_MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word accesses are rejected with rsp_err; otherwise they are force-aligned.
module dmem_responder #(
   parameter int DM_ADDRESS  = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   dmem_responder_if.slave   bus
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [DM_ADDRESS-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [2:0]            f3_q, f3_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic [7:0]            mem [0:(2**DM_ADDRESS)-1];

   logic                  legal, misal, acc_err, mem_wr;
   logic [DM_ADDRESS-1:0] a0, a1, a2, a3;
   logic [7:0]            b0, b1, b2, b3;
   logic [DATA_W-1:0]     ld_data, acc_rdata;

   // Decode the latched request: legality, effective address, byte lanes and load result
   always_comb begin
      legal = we_q ? (f3_q inside {3'b000, 3'b001, 3'b010})
                   : (f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      misal = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
              ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
      a0    = addr_q;
`ifdef DMEM_MISALIGN_TRAP_EN
      acc_err = !legal || misal;
`else
      acc_err = !legal;
      if (f3_q[1:0] == 2'b01) a0[0] = 1'b0;
      if (f3_q[1:0] == 2'b10) a0[1:0] = 2'b00;
`endif
      // Lane addresses wrap naturally at the store depth
      a1 = a0 + DM_ADDRESS'(1);
      a2 = a0 + DM_ADDRESS'(2);
      a3 = a0 + DM_ADDRESS'(3);
      b0 = mem[a0];
      b1 = mem[a1];
      b2 = mem[a2];
      b3 = mem[a3];
      case (f3_q)
         3'b000:  ld_data = {{24{b0[7]}}, b0};
         3'b001:  ld_data = {{16{b1[7]}}, b1, b0};
         3'b010:  ld_data = {b3, b2, b1, b0};
         3'b100:  ld_data = {24'h000000, b0};
         3'b101:  ld_data = {16'h0000, b1, b0};
         default: ld_data = '0;
      endcase
      acc_rdata = (acc_err || we_q) ? '0 : ld_data;
      mem_wr    = (state_q == S_WAIT) && (cnt_q == 4'd0) && we_q && !acc_err;
   end

   // Store write port; contents survive reset
   always_ff @(posedge clk) begin
      if (mem_wr) begin
         mem[a0] <= wdata_q[7:0];
         if (f3_q[1:0] != 2'b00) mem[a1] <= wdata_q[15:8];
         if (f3_q[1:0] == 2'b10) begin
            mem[a2] <= wdata_q[23:16];
            mem[a3] <= wdata_q[31:24];
         end
      end
   end

   // Next-state and next-value logic of the access FSM
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               f3_d    = bus.req_funct3;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               rdata_d = acc_rdata;
               err_d   = acc_err;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and response registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Latched request fields; only meaningful once a request has been accepted
   always_ff @(posedge clk) begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
   end

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.rsp_valid = (state_q == S_RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

endmodule
